// File: rtl/fir_coeff_seq_ctrl.sv
// fir_coeff_seq_ctrl: per-sample coefficient read bursts plus host bank rewrites for the FIR filter.
module fir_coeff_seq_ctrl #(
  parameter int NUM_TAP = 10,
  parameter int TAP_W = 4,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16,
  parameter int IN_W = 3,
  parameter logic [TAP_W-1:0] END_ADDR = 4'hB
) (
  input  logic                    iClk12M,
  input  logic                    iRsn,
  input  logic                    iEnSample600k,
  input  logic [IN_W-1:0]         iSample,
  input  logic [BANK_W-1:0]       iRdBank,
  input  logic                    iUpdReq,
  input  logic [BANK_W-1:0]       iUpdBank,
  input  logic                    iUpdValid,
  input  logic [DATA_W-1:0]       iUpdData,
  output logic                    oUpdAck,
  output logic                    oUpdReady,
  output logic                    oUpdDone,
  output logic                    oCoeffUpdateFlag,
  output logic                    oMemRdFlag,
  output logic [BANK_W+TAP_W-1:0] oAddrRam,
  output logic [DATA_W-1:0]       oWtDtRam,
  output logic [IN_W-1:0]         oFirIn,
  output logic                    oBusy,
  output logic                    oSampleMiss
);
  typedef enum logic [2:0] {IDLE, RD_START, RD_TAP, RD_END, WR_START, WR_DATA, WR_END} state_t;
  localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAP - 1);
  localparam logic [TAP_W-1:0] T0 = '0;
  state_t state, state_d;
  logic [TAP_W-1:0] tap, tap_d;
  logic [BANK_W-1:0] rd_bank, rd_bank_d, upd_bank, upd_bank_d;
  logic pend, pend_d, go_rd, start_rd;
  logic [IN_W-1:0] samp, samp_d, fir_d;
  logic ack_d, ready_d, done_d, cu_d, rd_d, busy_d, miss_d;
  logic [BANK_W+TAP_W-1:0] addr_d;
  logic [DATA_W-1:0] wd_d;
  assign go_rd = pend | iEnSample600k;
  // Outputs are computed for the next state and registered, so they line up with the state register.
  always_comb begin
    state_d = state;
    tap_d = tap;
    rd_bank_d = rd_bank;
    upd_bank_d = upd_bank;
    pend_d = pend | iEnSample600k;
    samp_d = iEnSample600k ? iSample : samp;
    miss_d = iEnSample600k & pend;
    start_rd = 1'b0;
    ack_d = 1'b0;
    ready_d = 1'b0;
    done_d = 1'b0;
    cu_d = 1'b0;
    rd_d = 1'b0;
    addr_d = '0;
    wd_d = '0;
    fir_d = '0;
    case (state)
      IDLE: begin
        if (go_rd) start_rd = 1'b1;
        else if (iUpdReq) begin
          state_d = WR_START;
          ack_d = 1'b1;
          cu_d = 1'b1;
          upd_bank_d = iUpdBank;
          addr_d = {iUpdBank, T0};
          tap_d = T0;
        end
      end
      RD_START: begin
        state_d = RD_TAP;
        rd_d = 1'b1;
        addr_d = {rd_bank, T0};
      end
      RD_TAP: begin
        rd_d = tap != LAST;
        state_d = tap == LAST ? RD_END : RD_TAP;
        tap_d = tap == LAST ? T0 : tap + 1'b1;
        addr_d = {rd_bank, tap_d};
      end
      RD_END: state_d = IDLE;
      WR_START: begin
        state_d = WR_DATA;
        cu_d = 1'b1;
        ready_d = 1'b1;
        addr_d = oAddrRam;
      end
      WR_DATA: begin
        cu_d = 1'b1;
        ready_d = 1'b1;
        addr_d = oAddrRam;
        wd_d = oWtDtRam;
        if (iUpdValid & oUpdReady) begin
          addr_d = {upd_bank, tap};
          wd_d = iUpdData;
          ready_d = tap != LAST;
          state_d = tap == LAST ? WR_END : WR_DATA;
          tap_d = tap == LAST ? T0 : tap + 1'b1;
        end
      end
      WR_END: begin
        if (tap == T0) begin
          cu_d = 1'b1;
          addr_d = {upd_bank, END_ADDR};
          tap_d = TAP_W'(1);
        end else begin
          done_d = 1'b1;
          tap_d = T0;
          state_d = IDLE;
          start_rd = go_rd;
        end
      end
      default: state_d = IDLE;
    endcase
    // A sample held off by a write is served straight out of the write tail.
    if (start_rd) begin
      state_d = RD_START;
      pend_d = 1'b0;
      rd_d = 1'b1;
      fir_d = samp_d;
      rd_bank_d = iRdBank;
      addr_d = {iRdBank, T0};
      tap_d = T0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
      tap <= '0;
      rd_bank <= '0;
      upd_bank <= '0;
      pend <= 1'b0;
      samp <= '0;
      oUpdAck <= 1'b0;
      oUpdReady <= 1'b0;
      oUpdDone <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oMemRdFlag <= 1'b0;
      oAddrRam <= '0;
      oWtDtRam <= '0;
      oFirIn <= '0;
      oBusy <= 1'b0;
      oSampleMiss <= 1'b0;
    end else begin
      state <= state_d;
      tap <= tap_d;
      rd_bank <= rd_bank_d;
      upd_bank <= upd_bank_d;
      pend <= pend_d;
      samp <= samp_d;
      oUpdAck <= ack_d;
      oUpdReady <= ready_d;
      oUpdDone <= done_d;
      oCoeffUpdateFlag <= cu_d;
      oMemRdFlag <= rd_d;
      oAddrRam <= addr_d;
      oWtDtRam <= wd_d;
      oFirIn <= fir_d;
      oBusy <= busy_d;
      oSampleMiss <= miss_d;
    end
  end
endmodule
